// File: rtl/reset_button_conditioner.sv
// Board-input conditioner: reset with async assert, sync release and a minimum
// hold, plus per-button synchronise/debounce with one-cycle press/release pulses.
module reset_button_conditioner #(
   parameter int sync_stages_p       = 2,
   parameter int num_buttons_p       = 3,
   parameter int debounce_cycles_p   = 250000,
   parameter int reset_hold_cycles_p = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_n_async_i,
   input  logic [num_buttons_p-1:0] button_async_unsafe_i,
   output logic                     reset_o,
   output logic [num_buttons_p-1:0] button_o,
   output logic [num_buttons_p-1:0] button_press_o,
   output logic [num_buttons_p-1:0] button_release_o
);

   localparam int hold_w_lp = $clog2(reset_hold_cycles_p + 1);
   localparam int deb_w_lp  = $clog2(debounce_cycles_p + 1);
   localparam logic [hold_w_lp-1:0] hold_last_lp = hold_w_lp'(reset_hold_cycles_p - 1);
   localparam logic [deb_w_lp-1:0]  deb_last_lp  = deb_w_lp'(debounce_cycles_p - 1);

   logic [sync_stages_p-1:0] rst_sync_q, rst_sync_d;
   logic [hold_w_lp-1:0]     hold_cnt_q, hold_cnt_d;
   logic                     reset_q, reset_d;

   // Hold counter only runs once the constant-1 has reached the last stage.
   always_comb begin
      rst_sync_d = {rst_sync_q[sync_stages_p-2:0], 1'b1};
      hold_cnt_d = hold_cnt_q;
      reset_d    = reset_q;
      if (reset_q && rst_sync_q[sync_stages_p-1]) begin
         hold_cnt_d = hold_cnt_q + hold_w_lp'(1);
         if (hold_cnt_q == hold_last_lp) reset_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_async_i) begin
      if (!reset_n_async_i) begin
         rst_sync_q <= '0;
         hold_cnt_q <= '0;
         reset_q    <= 1'b1;
      end else begin
         rst_sync_q <= rst_sync_d;
         hold_cnt_q <= hold_cnt_d;
         reset_q    <= reset_d;
      end
   end

   assign reset_o = reset_q;

   for (genvar i = 0; i < num_buttons_p; i++) begin : g_btn
      logic [sync_stages_p-1:0] sync_q, sync_d;
      logic [deb_w_lp-1:0]      cnt_q, cnt_d;
      logic                     btn_q, btn_d;
      logic                     press_q, press_d;
      logic                     rel_q, rel_d;

      // Any cycle where synced agrees with the output restarts the count.
      always_comb begin
         sync_d = {sync_q[sync_stages_p-2:0], button_async_unsafe_i[i]};
         cnt_d  = '0;
         btn_d  = btn_q;
         if (reset_q) begin
            btn_d = 1'b0;
         end else if (sync_q[sync_stages_p-1] != btn_q) begin
            if (cnt_q == deb_last_lp) btn_d = ~btn_q;
            else                      cnt_d = cnt_q + deb_w_lp'(1);
         end
         press_d = btn_d & ~btn_q & ~reset_q;
         rel_d   = ~btn_d & btn_q & ~reset_q;
      end

      always_ff @(posedge clk_i or negedge reset_n_async_i) begin
         if (!reset_n_async_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            btn_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
            press_q <= press_d;
            rel_q   <= rel_d;
         end
      end

      assign button_o[i]         = btn_q;
      assign button_press_o[i]   = press_q;
      assign button_release_o[i] = rel_q;
   end

endmodule

// File: tb/tb_reset_button_conditioner.sv
// Scoreboard bench: each stimulus step queues the output word expected after the
// next clock edge; a monitor pops and compares it 1 time unit after that edge.
module tb_reset_button_conditioner;

   logic       clk;
   logic       rst_n;
   logic [2:0] btn;
   logic       reset_o;
   logic [2:0] button_o, button_press_o, button_release_o;
   logic [9:0] outv;

   typedef struct {
      int         cyc;
      string      tag;
      logic [9:0] v;
   } sb_t;

   sb_t sb[$];
   sb_t mon_e;
   int  cyc;
   int  n_vec;
   int  n_err;

   reset_button_conditioner #(
      .sync_stages_p      (2),
      .num_buttons_p      (3),
      .debounce_cycles_p  (4),
      .reset_hold_cycles_p(3)
   ) dut (
      .clk_i                (clk),
      .reset_n_async_i      (rst_n),
      .button_async_unsafe_i(btn),
      .reset_o              (reset_o),
      .button_o             (button_o),
      .button_press_o       (button_press_o),
      .button_release_o     (button_release_o)
   );

   assign outv = {reset_o, button_o, button_press_o, button_release_o};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [9:0] pk(input logic r, input logic [2:0] b,
                                     input logic [2:0] p, input logic [2:0] rl);
      return {r, b, p, rl};
   endfunction

   task automatic chk(input string tag, input logic [9:0] act, input logic [9:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got r=%b b=%b p=%b rl=%b want r=%b b=%b p=%b rl=%b",
                  tag, cyc, act[9], act[8:6], act[5:3], act[2:0],
                  exp[9], exp[8:6], exp[5:3], exp[2:0]);
      end
   endtask

   // Queue the word expected after the next edge, then move to the next falling edge.
   task automatic step(input string tag, input logic [9:0] v);
      sb.push_back('{cyc + 1, tag, v});
      @(negedge clk);
   endtask

   task automatic steps(input int n, input string tag, input logic [9:0] v);
      for (int k = 0; k < n; k++) step(tag, v);
   endtask

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1;
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            chk(mon_e.tag, outv, mon_e.v);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [8:0] bounce;
      n_vec  = 0;
      n_err  = 0;
      bounce = 9'b101101111;
      rst_n  = 1'b0;
      btn    = 3'b000;

      // power-on: reset held 5 cycles, release, falls on 5th edge after release
      steps(5, "por_hold", pk(1, 3'b000, 3'b000, 3'b000));
      rst_n = 1'b1;
      steps(4, "por_rel", pk(1, 3'b000, 3'b000, 3'b000));
      steps(100, "por_run", pk(0, 3'b000, 3'b000, 3'b000));

      // glitch: reset reasserts with no clock, glitch again mid-chain
      rst_n = 1'b0;
      #1 chk("glitch_async1", outv, pk(1, 3'b000, 3'b000, 3'b000));
      step("glitch_low1", pk(1, 3'b000, 3'b000, 3'b000));
      rst_n = 1'b1;
      steps(2, "glitch_rel1", pk(1, 3'b000, 3'b000, 3'b000));
      rst_n = 1'b0;
      #1 chk("glitch_async2", outv, pk(1, 3'b000, 3'b000, 3'b000));
      step("glitch_low2", pk(1, 3'b000, 3'b000, 3'b000));
      rst_n = 1'b1;
      steps(4, "glitch_rel2", pk(1, 3'b000, 3'b000, 3'b000));
      steps(10, "glitch_done", pk(0, 3'b000, 3'b000, 3'b000));

      // clean press on bit 0: output at edge 6 after first sampling edge
      btn = 3'b001;
      steps(5, "press_wait", pk(0, 3'b000, 3'b000, 3'b000));
      step("press_edge", pk(0, 3'b001, 3'b001, 3'b000));
      steps(4, "press_hold", pk(0, 3'b001, 3'b000, 3'b000));

      // bounce shorter than the debounce window never changes the output
      for (int k = 8; k >= 0; k--) begin
         btn[0] = bounce[k];
         step("bounce", pk(0, 3'b001, 3'b000, 3'b000));
      end
      btn[0] = 1'b1;
      steps(6, "bounce_hold", pk(0, 3'b001, 3'b000, 3'b000));

      // bit 0 falls and bit 2 rises together
      btn = 3'b100;
      steps(5, "swap_wait", pk(0, 3'b001, 3'b000, 3'b000));
      step("swap_edge", pk(0, 3'b100, 3'b100, 3'b001));
      steps(3, "swap_hold", pk(0, 3'b100, 3'b000, 3'b000));

      // clear all buttons
      btn = 3'b000;
      steps(5, "clr_wait", pk(0, 3'b100, 3'b000, 3'b000));
      step("clr_edge", pk(0, 3'b000, 3'b000, 3'b100));
      step("clr_hold", pk(0, 3'b000, 3'b000, 3'b000));

      // reset in the middle of a debounce: count restarts after reset_o falls
      btn = 3'b010;
      steps(3, "mid_deb", pk(0, 3'b000, 3'b000, 3'b000));
      rst_n = 1'b0;
      #1 chk("mid_async", outv, pk(1, 3'b000, 3'b000, 3'b000));
      steps(2, "mid_low", pk(1, 3'b000, 3'b000, 3'b000));
      rst_n = 1'b1;
      steps(4, "mid_hold", pk(1, 3'b000, 3'b000, 3'b000));
      steps(4, "mid_restart", pk(0, 3'b000, 3'b000, 3'b000));
      step("mid_edge", pk(0, 3'b010, 3'b010, 3'b000));
      steps(3, "mid_after", pk(0, 3'b010, 3'b000, 3'b000));

      chk("sb_drain", 10'(sb.size()), 10'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
